// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: writable program memory, program counter and the
// FETCH/LOAD/EXEC sequencer that feeds the instruction register.
module instr_fetch_unit #(
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               clb,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               run,
    input  logic               restart,
    input  logic               exec_done,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               halt_req,
    output logic [INSTR_W-1:0] instr_out,
    output logic               load_ir,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_HALT
    } state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc_next;
    logic [INSTR_W-1:0] instr_next;
    logic               load_ir_next;
    logic               halted_next;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] mem_rd;
    logic               prog_allowed;

    assign mem_rd       = mem[pc];
    assign prog_allowed = (state == S_IDLE) || (state == S_HALT);
    assign busy         = (state == S_FETCH) || (state == S_LOAD) || (state == S_EXEC);

    // NOTE: the memory has no reset so it maps onto RAM and keeps the program across clb.
    always_ff @(posedge clk) begin
        if (prog_we && prog_allowed) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            state     <= S_IDLE;
            pc        <= '0;
            instr_out <= '0;
            load_ir   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            instr_out <= instr_next;
            load_ir   <= load_ir_next;
            halted    <= halted_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_next   = state;
        pc_next      = pc;
        instr_next   = instr_out;
        load_ir_next = load_ir;
        halted_next  = halted;

        unique case (state)
            S_IDLE: begin
                if (restart) begin
                    pc_next = '0;
                end else if (run) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_next   = mem_rd;
                load_ir_next = 1'b1;
                state_next   = S_LOAD;
            end
            S_LOAD: begin
                load_ir_next = 1'b0;
                pc_next      = pc + ADDR_W'(1);
                state_next   = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (halt_req) begin
                        halted_next = 1'b1;
                        state_next  = S_HALT;
                    end else begin
                        if (jump_en) begin
                            pc_next = jump_addr;
                        end
                        state_next = run ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_HALT: begin
                if (restart) begin
                    pc_next     = '0;
                    halted_next = 1'b0;
                    state_next  = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: sequential fetch, jump with
// wrap, halt priority, write protection, pause/resume and asynchronous clear.
module tb_instr_fetch_unit;

    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 16;
    localparam int INSTR_W = 8;

    logic               clk = 1'b0;
    logic               clb;
    logic               prog_we;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               run;
    logic               restart;
    logic               exec_done;
    logic               jump_en;
    logic [ADDR_W-1:0]  jump_addr;
    logic               halt_req;
    logic [INSTR_W-1:0] instr_out;
    logic               load_ir;
    logic [ADDR_W-1:0]  pc;
    logic               halted;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .INSTR_W(INSTR_W)
    ) dut (
        .clk      (clk),
        .clb      (clb),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .run      (run),
        .restart  (restart),
        .exec_done(exec_done),
        .jump_en  (jump_en),
        .jump_addr(jump_addr),
        .halt_req (halt_req),
        .instr_out(instr_out),
        .load_ir  (load_ir),
        .pc       (pc),
        .halted   (halted),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // Entered one edge after the unit moved to FETCH; leaves one edge after exec_done.
    task automatic fetch_one(input string name, input logic [INSTR_W-1:0] exp_instr,
                             input logic [ADDR_W-1:0] exp_pc, input logic jmp,
                             input logic [ADDR_W-1:0] jaddr, input logic halt,
                             input logic run_after, input int exec_wait, input logic try_write);
        logic [ADDR_W-1:0] exp_next;
        exp_next = exp_pc + 4'd1;
        n_checks++;
        if (busy !== 1'b1 || load_ir !== 1'b0) begin
            n_fail++;
            $display("FAIL %s fetch_state: busy=%b load_ir=%b, expected busy=1 load_ir=0", name, busy, load_ir);
        end
        tick();
        n_checks++;
        if (load_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL %s load_strobe: load_ir=%b, expected 1", name, load_ir);
        end
        n_checks++;
        if (instr_out !== exp_instr) begin
            n_fail++;
            $display("FAIL %s instr: instr_out=%h, expected %h", name, instr_out, exp_instr);
        end
        n_checks++;
        if (pc !== exp_pc) begin
            n_fail++;
            $display("FAIL %s pc_in_load: pc=%h, expected %h", name, pc, exp_pc);
        end
        tick();
        n_checks++;
        if (load_ir !== 1'b0 || pc !== exp_next) begin
            n_fail++;
            $display("FAIL %s exec_entry: load_ir=%b pc=%h, expected load_ir=0 pc=%h", name, load_ir, pc, exp_next);
        end
        run = run_after;
        if (try_write) begin
            prog_we   = 1'b1;
            prog_addr = exp_next;
            prog_data = 8'hEE;
        end
        for (int i = 0; i < exec_wait; i++) begin
            tick();
            prog_we = 1'b0;
            n_checks++;
            if (load_ir !== 1'b0 || busy !== 1'b1 || instr_out !== exp_instr) begin
                n_fail++;
                $display("FAIL %s exec_hold: load_ir=%b busy=%b instr_out=%h, expected 0 1 %h",
                         name, load_ir, busy, instr_out, exp_instr);
            end
        end
        prog_we   = 1'b0;
        exec_done = 1'b1;
        jump_en   = jmp;
        jump_addr = jaddr;
        halt_req  = halt;
        tick();
        exec_done = 1'b0;
        jump_en   = 1'b0;
        halt_req  = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if (pc !== 4'h0 || instr_out !== 8'h00 || load_ir !== 1'b0 || halted !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h instr_out=%h load_ir=%b halted=%b busy=%b, expected all zero",
                     pc, instr_out, load_ir, halted, busy);
        end
        @(posedge clk);
        #1;
        clb = 1'b1;
    endtask

    task automatic test_sequential;
        write_mem(4'h0, 8'h1A);
        write_mem(4'h1, 8'h2B);
        write_mem(4'h2, 8'hF0);
        write_mem(4'h4, 8'h4D);
        write_mem(4'h5, 8'h5E);
        write_mem(4'h6, 8'h6F);
        write_mem(4'hE, 8'h55);
        write_mem(4'hF, 8'h66);
        run = 1'b1;
        tick();
        fetch_one("seq0", 8'h1A, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
        fetch_one("seq1", 8'h2B, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
        fetch_one("seq2", 8'hF0, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 0, 1'b0);
        n_checks++;
        if (busy !== 1'b0 || pc !== 4'h3) begin
            n_fail++;
            $display("FAIL seq_stop: busy=%b pc=%h, expected busy=0 pc=3", busy, pc);
        end
    endtask

    task automatic test_jump;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_checks++;
        if (pc !== 4'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_restart: pc=%h busy=%b, expected pc=0 busy=0", pc, busy);
        end
        run = 1'b1;
        tick();
        fetch_one("jmp0", 8'h1A, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
        fetch_one("jmp1", 8'h2B, 4'h1, 1'b1, 4'hE, 1'b0, 1'b1, 0, 1'b0);
        fetch_one("jmpE", 8'h55, 4'hE, 1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
        // Fetch at F wraps pc to 0; halt and jump together, halt must win.
        fetch_one("jmpF", 8'h66, 4'hF, 1'b1, 4'h5, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_halt;
        n_checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 4'h0) begin
            n_fail++;
            $display("FAIL halt_entry: halted=%b busy=%b pc=%h, expected 1 0 0", halted, busy, pc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (load_ir !== 1'b0 || halted !== 1'b1 || pc !== 4'h0) begin
                n_fail++;
                $display("FAIL halt_hold: load_ir=%b halted=%b pc=%h, expected 0 1 0", load_ir, halted, pc);
            end
        end
        write_mem(4'h3, 8'hC3);
        run     = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_checks++;
        if (halted !== 1'b0 || pc !== 4'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_restart: halted=%b pc=%h busy=%b, expected 0 0 0", halted, pc, busy);
        end
    endtask

    task automatic test_write_protect;
        run = 1'b1;
        tick();
        fetch_one("wp0", 8'h1A, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1, 1'b1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        run = 1'b1;
        tick();
        fetch_one("wp_a0", 8'h1A, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
        fetch_one("wp_a1", 8'h2B, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
        fetch_one("wp_a2", 8'hF0, 4'h2, 1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
        fetch_one("wp_a3", 8'hC3, 4'h3, 1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_pause;
        fetch_one("pause4", 8'h4D, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (busy !== 1'b0 || pc !== 4'h5 || load_ir !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_idle: busy=%b pc=%h load_ir=%b, expected 0 5 0", busy, pc, load_ir);
            end
            tick();
        end
        run = 1'b1;
        tick();
        fetch_one("resume5", 8'h5E, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_async_reset;
        tick();
        n_checks++;
        if (load_ir !== 1'b1 || instr_out !== 8'h6F || pc !== 4'h6) begin
            n_fail++;
            $display("FAIL pre_clear_load: load_ir=%b instr_out=%h pc=%h, expected 1 6f 6", load_ir, instr_out, pc);
        end
        #2;
        run = 1'b0;
        clb = 1'b0;
        #1;
        n_checks++;
        if (load_ir !== 1'b0 || pc !== 4'h0 || instr_out !== 8'h00 || halted !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: load_ir=%b pc=%h instr_out=%h halted=%b busy=%b, expected all zero",
                     load_ir, pc, instr_out, halted, busy);
        end
        @(posedge clk);
        #1;
        clb = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || pc !== 4'h0) begin
            n_fail++;
            $display("FAIL post_clear_idle: busy=%b pc=%h, expected 0 0", busy, pc);
        end
        run = 1'b1;
        tick();
        fetch_one("mem_kept", 8'h1A, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        clb       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        run       = 1'b0;
        restart   = 1'b0;
        exec_done = 1'b0;
        jump_en   = 1'b0;
        jump_addr = '0;
        halt_req  = 1'b0;

        test_reset();
        test_sequential();
        test_jump();
        test_halt();
        test_write_protect();
        test_pause();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
